matmul_sched: RTL and testbench
===============================

# matmul_sched

Job scheduler in front of the `matmul` engine. Host pushes matrix-multiply descriptors into a small FIFO. The block launches one job at a time on the engine, holds the engine's configuration inputs stable for the whole job, and detects completion. It then posts a completion record carrying the job ID and the measured run-time in cycles. It sits between the host/CSR layer and the engine's `go`/`ret` and configuration ports.

## Interface
- `MEM_AW`, 16, memory address width (matches engine).
- `DIM_BITS`, 16, stride/dimension width (matches engine).
- `DEPTH`, 4, descriptor FIFO entries; power of two, ≥2.
- `ID_W`, 8, job ID width.
- `CNT_W`, 32, run-time counter width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `job_vld` in 1: descriptor valid.
- `job_rdy` out 1: FIFO can accept.
- `job_id` in `ID_W`: job tag.
- `job_abase`, `job_bbase`, `job_cbase` in `MEM_AW`: matrix base addresses.
- `job_astride`, `job_bstride`, `job_cstride` in `DIM_BITS`: row strides.
- `job_arows`, `job_acols`, `job_bcols` in `DIM_BITS`: dimensions.
- `eng_go` out 1: engine start, level.
- `eng_ret` in 1: engine done flag.
- `eng_abase`, `eng_bbase`, `eng_cbase` out `MEM_AW`: configuration to engine.
- `eng_astride`, `eng_bstride`, `eng_cstride` out `DIM_BITS`: configuration to engine.
- `eng_arows`, `eng_acols`, `eng_bcols` out `DIM_BITS`: configuration to engine.
- `done_vld` out 1 / `done_rdy` in 1: completion handshake.
- `done_id` out `ID_W`: ID of the completed job.
- `done_cycles` out `CNT_W`: run-time of the completed job.
- `busy` out 1: state ≠ IDLE.
- `fifo_cnt` out `$clog2(DEPTH)+1`: FIFO occupancy.

## Operation
- **FIFO**
  - Push when `job_vld && job_rdy`; `job_rdy = (fifo_cnt != DEPTH)`, with no bypass on a same-cycle pop.
  - Push and pop may occur in the same cycle; the count is unchanged.
  - Stores all 10 descriptor fields.
- **State machine:** IDLE, RUN, CPL.
- **IDLE**
  - If FIFO is non-empty: pop the head and load all `eng_*` config registers and the ID register.
  - Set `eng_go<=1`, clear the cycle counter to 1, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN**
  - `eng_go` is held high; the engine samples `go` only in its wait state.
  - Counter increments each cycle, saturating at all-ones.
  - Completion is the **rising edge** of `eng_ret` (`eng_ret && !ret_q`). The engine holds `ret` high for 2 cycles, so level detection is forbidden.
  - On completion, `eng_go<=0`.
  - If `!done_vld || done_rdy`: load `done_id`/`done_cycles`, set `done_vld<=1`, go to IDLE.
  - Otherwise go to CPL with the record held internally.
- **CPL**
  - Wait for `!done_vld || done_rdy`, then load the done registers, set `done_vld<=1`, and go to IDLE.
  - No launch occurs while in CPL (back-pressure).
- **Completion output:** `done_vld` clears on `done_rdy` unless reloaded in the same cycle.
- **Config outputs:** `eng_*` change only on a launch and are stable from launch until the next launch.
- **Run-time:** `done_cycles` = number of cycles from the first cycle `eng_go==1` through the `ret`-rise cycle inclusive.
- **Zero dimensions** are passed through unchanged; the engine returns promptly.

## Timing
- **Reset values:**
  - `eng_go`, all `eng_*`, `done_vld`, `done_id`, `done_cycles`, `busy`, `fifo_cnt`, `ret_q` are 0; state is IDLE.
  - `job_rdy` is 1.
- **Launch latency:** a push at cycle t into an empty FIFO in IDLE gives `eng_go=1` at t+2 (write at t, pop decision at t+1).
- **Completion:** `ret` rise sampled at cycle c gives `eng_go=0` and `done_vld=1` at c+1. Earliest next `eng_go=1` is c+2, which coincides with the engine reaching its wait state.
- **Reset mid-operation:** asynchronously clears the FIFO, FSM, counter and done registers. The engine shares `rst_n`; no job is resumed.
- **Counter saturation:** the counter holds at 2^`CNT_W`−1 and never wraps.
- **`eng_ret` while not in RUN** is ignored; `ret_q` still tracks it.

## Test plan
- **Single job:** push ID=5 at t. Check `eng_go` rises at t+2 with the config equal to the pushed fields. Engine model raises `ret` 20 cycles after `go` for 2 cycles. Check `done_vld=1`, `done_id=5`, `done_cycles=21`, and `eng_go` low the cycle after the `ret` rise.
- **Back-to-back:** push 3 jobs (IDs 1,2,3) with `done_rdy=1`. Check three launches each exactly 2 cycles after the previous `ret` rise, records in order, and each config stable across its run.
- **FIFO full:** with the engine stalled (no `ret`), push 5 jobs with `DEPTH=4`. Check `job_rdy=0` once `fifo_cnt=4` (1 running + 4 queued) and that no entry is lost or duplicated.
- **Done back-pressure:** hold `done_rdy=0`. Job A completes, then job B completes and the FSM sits in CPL. Check job C is not launched until `done_rdy` pulses, and records A then B are presented in order.
- **Saturation:** with `CNT_W=4` and the engine taking 30 cycles, check `done_cycles=15`.
- **Reset mid-run:** assert `rst_n=0` during RUN with 2 jobs queued. Check all outputs return to their reset values immediately, `fifo_cnt=0`, and no `done_vld` after release.

Source files
------------

// File: rtl/matmul_sched.sv
// matmul_sched: descriptor FIFO plus launch/complete sequencer in front of
// the matmul engine. One job runs at a time; its configuration is held on
// eng_* from launch to the next launch, and its run-time is reported with
// its ID through a valid/ready completion record.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no job on the engine; pops the FIFO head when one is waiting
// RUN   | eng_go high, cycle counter running, watching for eng_ret rise
// CPL   | job finished but the completion slot is still occupied
module matmul_sched #(
  parameter int MEM_AW   = 16,
  parameter int DIM_BITS = 16,
  parameter int DEPTH    = 4,
  parameter int ID_W     = 8,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_vld,
  output logic                   job_rdy,
  input  logic [ID_W-1:0]        job_id,
  input  logic [MEM_AW-1:0]      job_abase,
  input  logic [MEM_AW-1:0]      job_bbase,
  input  logic [MEM_AW-1:0]      job_cbase,
  input  logic [DIM_BITS-1:0]    job_astride,
  input  logic [DIM_BITS-1:0]    job_bstride,
  input  logic [DIM_BITS-1:0]    job_cstride,
  input  logic [DIM_BITS-1:0]    job_arows,
  input  logic [DIM_BITS-1:0]    job_acols,
  input  logic [DIM_BITS-1:0]    job_bcols,
  output logic                   eng_go,
  input  logic                   eng_ret,
  output logic [MEM_AW-1:0]      eng_abase,
  output logic [MEM_AW-1:0]      eng_bbase,
  output logic [MEM_AW-1:0]      eng_cbase,
  output logic [DIM_BITS-1:0]    eng_astride,
  output logic [DIM_BITS-1:0]    eng_bstride,
  output logic [DIM_BITS-1:0]    eng_cstride,
  output logic [DIM_BITS-1:0]    eng_arows,
  output logic [DIM_BITS-1:0]    eng_acols,
  output logic [DIM_BITS-1:0]    eng_bcols,
  output logic                   done_vld,
  input  logic                   done_rdy,
  output logic [ID_W-1:0]        done_id,
  output logic [CNT_W-1:0]       done_cycles,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = ID_W + 3 * MEM_AW + 6 * DIM_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CPL  = 2'd2
  } state_t;

  logic [DW-1:0]       r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_cnt;

  state_t              r_state;
  logic                r_ret_q;
  logic                r_go;
  logic [ID_W-1:0]     r_id;
  logic [CNT_W-1:0]    r_cyc;
  logic                r_done_vld;
  logic [ID_W-1:0]     r_done_id;
  logic [CNT_W-1:0]    r_done_cycles;
  logic [MEM_AW-1:0]   r_abase, r_bbase, r_cbase;
  logic [DIM_BITS-1:0] r_astride, r_bstride, r_cstride;
  logic [DIM_BITS-1:0] r_arows, r_acols, r_bcols;

  logic                w_push;
  logic                w_pop;
  logic                w_ret_rise;
  logic                w_done_free;
  logic [CNT_W-1:0]    w_cyc_inc;
  logic [DW-1:0]       w_din;
  logic [ID_W-1:0]     w_h_id;
  logic [MEM_AW-1:0]   w_h_abase, w_h_bbase, w_h_cbase;
  logic [DIM_BITS-1:0] w_h_astride, w_h_bstride, w_h_cstride;
  logic [DIM_BITS-1:0] w_h_arows, w_h_acols, w_h_bcols;

  // A full FIFO refuses a push even if the head leaves in the same cycle.
  assign job_rdy  = (r_cnt != CW'(DEPTH));
  assign w_push   = job_vld && job_rdy;
  assign w_pop    = (r_state == S_IDLE) && (r_cnt != '0);
  assign fifo_cnt = r_cnt;

  assign w_din = {job_id, job_abase, job_bbase, job_cbase,
                  job_astride, job_bstride, job_cstride,
                  job_arows, job_acols, job_bcols};

  assign {w_h_id, w_h_abase, w_h_bbase, w_h_cbase,
          w_h_astride, w_h_bstride, w_h_cstride,
          w_h_arows, w_h_acols, w_h_bcols} = r_mem[r_rptr];

  // The engine keeps ret high for two cycles, so only the first one counts.
  assign w_ret_rise  = eng_ret && !r_ret_q;
  assign w_done_free = !r_done_vld || done_rdy;
  assign w_cyc_inc   = (&r_cyc) ? r_cyc : r_cyc + CNT_W'(1);

  assign busy        = (r_state != S_IDLE);
  assign eng_go      = r_go;
  assign eng_abase   = r_abase;
  assign eng_bbase   = r_bbase;
  assign eng_cbase   = r_cbase;
  assign eng_astride = r_astride;
  assign eng_bstride = r_bstride;
  assign eng_cstride = r_cstride;
  assign eng_arows   = r_arows;
  assign eng_acols   = r_acols;
  assign eng_bcols   = r_bcols;
  assign done_vld    = r_done_vld;
  assign done_id     = r_done_id;
  assign done_cycles = r_done_cycles;

  // Descriptor storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_din;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Launch / run / completion sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ret_q       <= 1'b0;
      r_go          <= 1'b0;
      r_id          <= '0;
      r_cyc         <= '0;
      r_done_vld    <= 1'b0;
      r_done_id     <= '0;
      r_done_cycles <= '0;
      r_abase       <= '0;
      r_bbase       <= '0;
      r_cbase       <= '0;
      r_astride     <= '0;
      r_bstride     <= '0;
      r_cstride     <= '0;
      r_arows       <= '0;
      r_acols       <= '0;
      r_bcols       <= '0;
    end else begin
      r_ret_q <= eng_ret;
      if (done_rdy) r_done_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_id      <= w_h_id;
            r_abase   <= w_h_abase;
            r_bbase   <= w_h_bbase;
            r_cbase   <= w_h_cbase;
            r_astride <= w_h_astride;
            r_bstride <= w_h_bstride;
            r_cstride <= w_h_cstride;
            r_arows   <= w_h_arows;
            r_acols   <= w_h_acols;
            r_bcols   <= w_h_bcols;
            r_go      <= 1'b1;
            r_cyc     <= CNT_W'(1);
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_ret_rise) begin
            // Counter is frozen here so a parked record keeps its value.
            r_go <= 1'b0;
            if (w_done_free) begin
              r_done_id     <= r_id;
              r_done_cycles <= r_cyc;
              r_done_vld    <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_state <= S_CPL;
            end
          end else begin
            r_cyc <= w_cyc_inc;
          end
        end
        S_CPL: begin
          if (w_done_free) begin
            r_done_id     <= r_id;
            r_done_cycles <= r_cyc;
            r_done_vld    <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched: a 32-bit-counter instance driven by a
// small engine model, and a 4-bit-counter instance for saturation.
module tb_matmul_sched;

  localparam int CFG_W = 144;

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] abase, bbase, cbase;
    logic [15:0] astride, bstride, cstride;
    logic [15:0] arows, acols, bcols;
  } desc_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        job_vld, job_rdy;
  logic [7:0]  job_id;
  logic [15:0] job_abase, job_bbase, job_cbase;
  logic [15:0] job_astride, job_bstride, job_cstride;
  logic [15:0] job_arows, job_acols, job_bcols;
  logic        eng_go, eng_ret;
  logic [15:0] eng_abase, eng_bbase, eng_cbase;
  logic [15:0] eng_astride, eng_bstride, eng_cstride;
  logic [15:0] eng_arows, eng_acols, eng_bcols;
  logic        done_vld, done_rdy;
  logic [7:0]  done_id;
  logic [31:0] done_cycles;
  logic        busy;
  logic [2:0]  fifo_cnt;

  logic        job_vld2, job_rdy2, eng_go2, eng_ret2;
  logic [15:0] e2_abase, e2_bbase, e2_cbase;
  logic [15:0] e2_astride, e2_bstride, e2_cstride;
  logic [15:0] e2_arows, e2_acols, e2_bcols;
  logic        done_vld2, done_rdy2;
  logic [7:0]  done_id2;
  logic [3:0]  done_cycles2;
  logic        busy2;
  logic [2:0]  fifo_cnt2;

  matmul_sched #(.MEM_AW(16), .DIM_BITS(16), .DEPTH(4), .ID_W(8), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .job_vld(job_vld), .job_rdy(job_rdy), .job_id(job_id),
    .job_abase(job_abase), .job_bbase(job_bbase), .job_cbase(job_cbase),
    .job_astride(job_astride), .job_bstride(job_bstride), .job_cstride(job_cstride),
    .job_arows(job_arows), .job_acols(job_acols), .job_bcols(job_bcols),
    .eng_go(eng_go), .eng_ret(eng_ret),
    .eng_abase(eng_abase), .eng_bbase(eng_bbase), .eng_cbase(eng_cbase),
    .eng_astride(eng_astride), .eng_bstride(eng_bstride), .eng_cstride(eng_cstride),
    .eng_arows(eng_arows), .eng_acols(eng_acols), .eng_bcols(eng_bcols),
    .done_vld(done_vld), .done_rdy(done_rdy), .done_id(done_id),
    .done_cycles(done_cycles), .busy(busy), .fifo_cnt(fifo_cnt)
  );

  matmul_sched #(.MEM_AW(16), .DIM_BITS(16), .DEPTH(4), .ID_W(8), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .job_vld(job_vld2), .job_rdy(job_rdy2), .job_id(job_id),
    .job_abase(job_abase), .job_bbase(job_bbase), .job_cbase(job_cbase),
    .job_astride(job_astride), .job_bstride(job_bstride), .job_cstride(job_cstride),
    .job_arows(job_arows), .job_acols(job_acols), .job_bcols(job_bcols),
    .eng_go(eng_go2), .eng_ret(eng_ret2),
    .eng_abase(e2_abase), .eng_bbase(e2_bbase), .eng_cbase(e2_cbase),
    .eng_astride(e2_astride), .eng_bstride(e2_bstride), .eng_cstride(e2_cstride),
    .eng_arows(e2_arows), .eng_acols(e2_acols), .eng_bcols(e2_bcols),
    .done_vld(done_vld2), .done_rdy(done_rdy2), .done_id(done_id2),
    .done_cycles(done_cycles2), .busy(busy2), .fifo_cnt(fifo_cnt2)
  );

  logic [CFG_W-1:0] cfg1, cfg2;
  assign cfg1 = {eng_abase, eng_bbase, eng_cbase, eng_astride, eng_bstride,
                 eng_cstride, eng_arows, eng_acols, eng_bcols};
  assign cfg2 = {e2_abase, e2_bbase, e2_cbase, e2_astride, e2_bstride,
                 e2_cstride, e2_arows, e2_acols, e2_bcols};

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic desc_t mk(input logic [7:0] id, input logic [15:0] base,
                               input logic [15:0] r, input logic [15:0] c,
                               input logic [15:0] bc);
    desc_t d;
    d.id      = id;
    d.abase   = base;
    d.bbase   = base + 16'h0100;
    d.cbase   = base + 16'h0200;
    d.astride = c;
    d.bstride = bc;
    d.cstride = bc + 16'd1;
    d.arows   = r;
    d.acols   = c;
    d.bcols   = bc;
    return d;
  endfunction

  task automatic drive(input desc_t d);
    job_id      = d.id;
    job_abase   = d.abase;
    job_bbase   = d.bbase;
    job_cbase   = d.cbase;
    job_astride = d.astride;
    job_bstride = d.bstride;
    job_cstride = d.cstride;
    job_arows   = d.arows;
    job_acols   = d.acols;
    job_bcols   = d.bcols;
  endtask

  desc_t       exp_q[$];
  int          launch_cyc[$];
  int          rise_cyc[$];
  logic [7:0]  dn_id[$];
  logic [31:0] dn_cyc[$];
  int          cfg_bad = 0;
  int          dv_seen = 0;

  // Engine model: starts when it sees go, raises ret eng_lat cycles later
  // for two cycles. eng_hold parks it in its wait state.
  int eng_lat  = 20;
  bit eng_hold = 1'b0;
  bit e_busy   = 1'b0;
  int e_age    = 0;

  initial begin
    eng_ret = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        e_busy  = 1'b0;
        eng_ret = 1'b0;
      end else begin
        if (e_busy && !eng_hold) begin
          e_age++;
          if (e_age == eng_lat) eng_ret = 1'b1;
          else if (e_age == eng_lat + 2) begin
            eng_ret = 1'b0;
            e_busy  = 1'b0;
          end
        end
        if (!e_busy && eng_go && !eng_hold) begin
          e_busy = 1'b1;
          e_age  = 0;
        end
      end
    end
  end

  // Monitor: launches against pushed descriptors, config stability, ret
  // rises and accepted completion records.
  initial begin
    bit    go_p  = 1'b0;
    bit    ret_p = 1'b0;
    desc_t cur   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        go_p  = 1'b0;
        ret_p = 1'b0;
      end else begin
        if (eng_go && !go_p) begin
          launch_cyc.push_back(cyc);
          chk("launch_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("launch_cfg", cfg1, cur[CFG_W-1:0]);
          end
        end
        if (eng_go && cfg1 !== cur[CFG_W-1:0]) cfg_bad++;
        if (eng_ret && !ret_p) rise_cyc.push_back(cyc);
        if (done_vld && done_rdy) begin
          dn_id.push_back(done_id);
          dn_cyc.push_back(done_cycles);
        end
        if (done_vld) dv_seen++;
        go_p  = eng_go;
        ret_p = eng_ret;
      end
    end
  end

  task automatic clear_logs();
    launch_cyc.delete();
    rise_cyc.delete();
    dn_id.delete();
    dn_cyc.delete();
    cfg_bad = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    chk("wait_idle", busy, 0);
  endtask

  // Called at a negedge; returns at the following negedge with job_vld low.
  task automatic push(input desc_t d);
    drive(d);
    job_vld = 1'b1;
    for (int i = 0; i < 100 && !job_rdy; i++) @(negedge clk);
    chk("push_rdy", job_rdy, 1);
    exp_q.push_back(d);
    @(negedge clk);
    job_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    desc_t d;
    int    k;
    int    p;
    int    r_rel;

    rst_n     = 1'b0;
    job_vld   = 1'b0;
    job_vld2  = 1'b0;
    eng_ret2  = 1'b0;
    done_rdy  = 1'b1;
    done_rdy2 = 1'b1;
    drive('0);

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_go", eng_go, 0);
    chk("rst_cfg", cfg1, 0);
    chk("rst_done_vld", done_vld, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_done_cycles", done_cycles, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_job_rdy", job_rdy, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single job: go two cycles after push, done 21 cycles after go
    clear_logs();
    d = mk(8'd5, 16'h1000, 16'd4, 16'd3, 16'd2);
    push(d);
    chk("s_go_t1", eng_go, 0);
    chk("s_cnt_t1", fifo_cnt, 1);
    @(negedge clk);
    chk("s_go_t2", eng_go, 1);
    chk("s_busy", busy, 1);
    chk("s_cnt_t2", fifo_cnt, 0);
    chk("s_cfg", cfg1, d[CFG_W-1:0]);
    for (k = 0; k < 100 && !done_vld; k++) @(negedge clk);
    chk("s_done_lat", k, 21);
    chk("s_done_id", done_id, 5);
    chk("s_done_cycles", done_cycles, 21);
    chk("s_go_low", eng_go, 0);
    @(negedge clk);
    chk("s_done_clr", done_vld, 0);
    chk("s_idle", busy, 0);

    // back-to-back: three jobs, the middle one with zero dimensions
    clear_logs();
    push(mk(8'd1, 16'h2000, 16'd8, 16'd8, 16'd8));
    push(mk(8'd2, 16'h3000, 16'd0, 16'd0, 16'd0));
    push(mk(8'd3, 16'h4000, 16'd1, 16'd2, 16'd3));
    for (int i = 0; i < 400 && dn_id.size() < 3; i++) @(negedge clk);
    chk("bb_n_done", dn_id.size(), 3);
    for (int j = 0; j < 3 && j < dn_id.size(); j++) begin
      chk("bb_id", dn_id[j], j + 1);
      chk("bb_cycles", dn_cyc[j], 21);
    end
    for (int j = 0; j < 2 && j + 1 < launch_cyc.size() && j < rise_cyc.size(); j++)
      chk("bb_gap", launch_cyc[j+1] - rise_cyc[j], 2);
    chk("bb_n_launch", launch_cyc.size(), 3);
    chk("bb_cfg_stable", cfg_bad, 0);

    // done back-pressure: A done, B parked in CPL, C must wait
    wait_idle();
    clear_logs();
    done_rdy = 1'b0;
    push(mk(8'd10, 16'h5000, 16'd2, 16'd2, 16'd2));
    push(mk(8'd11, 16'h6000, 16'd3, 16'd3, 16'd3));
    push(mk(8'd12, 16'h7000, 16'd4, 16'd4, 16'd4));
    for (int i = 0; i < 200 && rise_cyc.size() < 2; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("bp_n_launch", launch_cyc.size(), 2);
    chk("bp_go", eng_go, 0);
    chk("bp_busy", busy, 1);
    chk("bp_fifo_cnt", fifo_cnt, 1);
    chk("bp_vld_a", done_vld, 1);
    chk("bp_id_a", done_id, 10);
    chk("bp_cycles_a", done_cycles, 21);
    done_rdy = 1'b1;
    p = cyc;
    @(negedge clk);
    done_rdy = 1'b0;
    chk("bp_vld_b", done_vld, 1);
    chk("bp_id_b", done_id, 11);
    chk("bp_cycles_b", done_cycles, 21);
    for (int i = 0; i < 20 && launch_cyc.size() < 3; i++) @(negedge clk);
    chk("bp_n_launch_c", launch_cyc.size(), 3);
    if (launch_cyc.size() >= 3) chk("bp_launch_c", launch_cyc[2] - p, 2);
    done_rdy = 1'b1;
    for (int i = 0; i < 200 && dn_id.size() < 3; i++) @(negedge clk);
    chk("bp_n_done", dn_id.size(), 3);
    for (int j = 0; j < 3 && j < dn_id.size(); j++)
      chk("bp_order", dn_id[j], 10 + j);
    chk("bp_cfg_stable", cfg_bad, 0);

    // FIFO full: engine parked, one running plus four queued
    wait_idle();
    clear_logs();
    eng_hold = 1'b1;
    for (int j = 0; j < 5; j++)
      push(mk(8'(20 + j), 16'(16'h8000 + 16'(j) * 16'h0400), 16'(j + 1), 16'd5, 16'(9 - j)));
    chk("ff_cnt", fifo_cnt, 4);
    chk("ff_rdy", job_rdy, 0);
    chk("ff_go", eng_go, 1);
    drive(mk(8'd25, 16'hF000, 16'd1, 16'd1, 16'd1));
    job_vld = 1'b1;
    repeat (3) @(negedge clk);
    chk("ff_rdy_hold", job_rdy, 0);
    job_vld = 1'b0;
    chk("ff_cnt_hold", fifo_cnt, 4);
    r_rel = cyc;
    eng_hold = 1'b0;
    for (int i = 0; i < 400 && dn_id.size() < 5; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("ff_n_done", dn_id.size(), 5);
    for (int j = 0; j < 5 && j < dn_id.size(); j++)
      chk("ff_order", dn_id[j], 20 + j);
    if (launch_cyc.size() != 0 && dn_cyc.size() != 0)
      chk("ff_cycles_first", dn_cyc[0], r_rel + 21 - launch_cyc[0]);
    for (int j = 1; j < 5 && j < dn_cyc.size(); j++)
      chk("ff_cycles", dn_cyc[j], 21);
    chk("ff_empty", fifo_cnt, 0);
    chk("ff_idle", busy, 0);
    chk("ff_cfg_stable", cfg_bad, 0);

    // reset mid-run with two jobs queued
    clear_logs();
    eng_hold = 1'b1;
    push(mk(8'd30, 16'h9000, 16'd6, 16'd6, 16'd6));
    push(mk(8'd31, 16'hA000, 16'd6, 16'd6, 16'd6));
    push(mk(8'd32, 16'hB000, 16'd6, 16'd6, 16'd6));
    repeat (2) @(negedge clk);
    chk("rr_pre_cnt", fifo_cnt, 2);
    chk("rr_pre_go", eng_go, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_go", eng_go, 0);
    chk("rr_cfg", cfg1, 0);
    chk("rr_done_vld", done_vld, 0);
    chk("rr_done_id", done_id, 0);
    chk("rr_done_cycles", done_cycles, 0);
    chk("rr_busy", busy, 0);
    chk("rr_fifo_cnt", fifo_cnt, 0);
    chk("rr_job_rdy", job_rdy, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n    = 1'b1;
    eng_hold = 1'b0;
    dv_seen  = 0;
    launch_cyc.delete();
    repeat (30) @(negedge clk);
    chk("rr_no_done", dv_seen, 0);
    chk("rr_no_launch", launch_cyc.size(), 0);
    chk("rr_busy_after", busy, 0);

    // ret while idle is ignored
    eng_ret2 = 1'b1;
    repeat (2) @(negedge clk);
    eng_ret2 = 1'b0;
    chk("ig_done_vld", done_vld2, 0);
    chk("ig_busy", busy2, 0);
    @(negedge clk);

    // saturation: 4-bit counter, ret 30 cycles after go
    d = mk(8'd40, 16'hC000, 16'd7, 16'd7, 16'd7);
    drive(d);
    job_vld2 = 1'b1;
    chk("sat_rdy", job_rdy2, 1);
    @(negedge clk);
    job_vld2 = 1'b0;
    for (k = 0; k < 10 && !eng_go2; k++) @(negedge clk);
    chk("sat_launch_lat", k, 1);
    chk("sat_cfg", cfg2, d[CFG_W-1:0]);
    chk("sat_busy", busy2, 1);
    chk("sat_cnt", fifo_cnt2, 0);
    repeat (30) @(negedge clk);
    eng_ret2 = 1'b1;
    @(negedge clk);
    chk("sat_done_vld", done_vld2, 1);
    chk("sat_done_cycles", done_cycles2, 15);
    chk("sat_done_id", done_id2, 40);
    chk("sat_go_low", eng_go2, 0);
    @(negedge clk);
    eng_ret2 = 1'b0;
    chk("sat_done_clr", done_vld2, 0);
    chk("sat_idle", busy2, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
